spr_window_gen: RTL
===================

Name: spr_window_gen

Overview:
Parametrised sliding-window generator for the SPR pipeline. It takes multi-pixel-per-clock line data and emits, for each input group, that group plus PAD neighbour pixels on each side. At line start and line end the neighbour slots are filled by a selectable edge policy. It replaces the fixed 4-pixel/1-tap neighbour buffering and first/last-pixel muxing ahead of sharpness/core. It also supplies the odd/even line flag and a delayed-DE bus for downstream stage enables.

Parameters:
PPC, 4, pixels per clock per group
DW, 11, bits per colour component
NCH, 3, channels per pixel (ch0 in lowest bits)
PAD, 1, neighbour pixels on each side; 1 <= PAD <= PPC-1
DE_DLY, 20, length of delayed-DE bus

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_hs  in  1  line active (low = horizontal blank, clears line state)
i_vs  in  1  frame active (low = vertical blank, clears frame state, loads config)
i_de  in  1  input group valid; contiguous within a line
i_data  in  PPC*NCH*DW  group; pixel p at [(p*NCH+c)*DW +: DW]
i_pad_mode  in  2  0 zero, 1 replicate edge pixel, 2 mirror (edge excluded), 3 = replicate
o_valid  out  1  o_window valid
o_window  out  (PPC+2*PAD)*NCH*DW  slot s at [(s*NCH+c)*DW +: DW]; slot PAD = pixel 0 of group
o_first  out  1  window is first group of line
o_last  out  1  window is last group of line
o_odd_line  out  1  line parity, 0 for first line of frame
o_de_dly  out  DE_DLY  o_de_dly[k] = i_de delayed k+1 clocks

Behaviour:
- Reset (rst=1): state IDLE; o_valid, o_first, o_last, o_odd_line = 0; o_window = 0; o_de_dly = 0; pad_mode shadow = 0.
- Config: pad_mode shadow loads i_pad_mode on every cycle with i_vs=0. It is held constant while i_vs=1.
- Clear: i_vs=0 or i_hs=0 (and rst=0) sets state IDLE, prev/cur = 0, o_valid/o_first/o_last = 0, o_de_dly = 0. This aborts a line in progress with no flush window.
  - i_vs=0 also clears o_odd_line. i_hs=0 leaves it unchanged.
- Registers: prev (PAD right-most pixels of the previous group) and cur (full group).
- States: IDLE, FILL (one group held), RUN (two or more groups seen).
  - IDLE & i_de: cur <= i_data, first_pend <= 1, go FILL. o_valid <= 0.
  - FILL/RUN & i_de: emit window(cur) with left = prev or pad if first_pend, right = i_data pixels 0..PAD-1. Set o_first <= first_pend, o_last <= 0, o_valid <= 1. Then prev <= cur tail, cur <= i_data, first_pend <= 0, go RUN.
  - FILL/RUN & !i_de: flush. Emit window(cur) with right = pad, o_first <= first_pend, o_last <= 1, o_valid <= 1. Toggle o_odd_line on this same edge. Go IDLE.
  - Other cycles: o_valid <= 0. o_window holds its last value.
- Timing: if i_de is high in cycles 0..N-1, o_valid is high in cycles 2..N+1. Output count equals input count. N=1 gives one window with o_first = o_last = 1.
- Padding, shown for left side; right side mirrors with pixel PPC-1:
  - mode 0: slots 0..PAD-1 = 0.
  - mode 1/3: every left slot = pixel 0 of cur.
  - mode 2: slot PAD-1-j = pixel j+1 of cur.
  - Padding is applied per channel identically.
- Back-to-back lines: i_de may rise on the cycle right after the flush edge; IDLE accepts it normally.
- No arithmetic; data passes bit-exact. Any PAD/PPC combination that violates the parameter range is an elaboration error.

Test Plan:
- PPC=4,PAD=1, mode1, 3 groups with pixel values 1..12 (all channels) -> windows {1,1,2,3,4,5}, {4,5,6,7,8,9}, {8,9,10,11,12,12}; o_valid cycles 2-4; o_first on 1st, o_last on 3rd.
- Same data, mode0 -> first window slot0 = 0, last window slot5 = 0. Mode2 -> first slot0 = 2, last slot5 = 11.
- Single-group line {1,2,3,4}, mode1 -> one window {1,1,2,3,4,4}, o_first = o_last = 1, o_odd_line toggles 0->1.
- i_hs drops after 2 of 3 groups -> no further o_valid, o_last never asserted, o_odd_line unchanged. Next line starts with o_first.
- i_pad_mode changed while i_vs=1 -> no effect until after an i_vs=0 cycle. i_vs=0 clears o_odd_line to 0.
- rst pulsed mid-line -> next cycle all outputs 0, o_de_dly = 0. A new line after rst produces correct windows.

Source files
------------

// File: rtl/spr_window_gen.sv
// Sliding-window generator: emits each input group with PAD neighbours per side.
// Line edges are filled per the frame-latched pad mode; also line parity and DE delay.
module spr_window_gen #(
  parameter int PPC    = 4,
  parameter int DW     = 11,
  parameter int NCH    = 3,
  parameter int PAD    = 1,
  parameter int DE_DLY = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_hs,
  input  logic                          i_vs,
  input  logic                          i_de,
  input  logic [PPC*NCH*DW-1:0]         i_data,
  input  logic [1:0]                    i_pad_mode,
  output logic                          o_valid,
  output logic [(PPC+2*PAD)*NCH*DW-1:0] o_window,
  output logic                          o_first,
  output logic                          o_last,
  output logic                          o_odd_line,
  output logic [DE_DLY-1:0]             o_de_dly
);

  localparam int PW = NCH * DW;
  localparam int NS = PPC + 2 * PAD;

  generate
    if (PAD < 1 || PAD > PPC - 1) begin : g_bad_pad
      $error("spr_window_gen: PAD must be in 1..PPC-1");
    end
    if (DE_DLY < 1) begin : g_bad_dly
      $error("spr_window_gen: DE_DLY must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PPC-1:0][PW-1:0] in_px;
  logic [PPC-1:0][PW-1:0] cur;
  logic [PAD-1:0][PW-1:0] prev;
  logic [NS-1:0][PW-1:0]  win_q;
  logic [NS-1:0][PW-1:0]  win_nxt;
  logic [1:0]             mode_q;
  logic                   first_pend;
  logic                   clr;
  logic                   emit;
  logic                   flush;
  logic                   load;

  assign in_px    = i_data;
  assign o_window = win_q;
  assign clr      = !i_vs || !i_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    flush     = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_de) begin
          load      = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL, RUN: begin
        emit = 1'b1;
        if (i_de) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          flush     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
    end
  end

  // Mirror mode skips the edge pixel itself, hence PAD-j / PPC-2-j.
  always_comb begin
    win_nxt = '0;
    for (int s = 0; s < PPC; s++) begin
      win_nxt[PAD+s] = cur[s];
    end
    for (int j = 0; j < PAD; j++) begin
      if (!first_pend) begin
        win_nxt[j] = prev[j];
      end else begin
        unique case (1'b1)
          (mode_q == 2'd0): win_nxt[j] = '0;
          (mode_q == 2'd2): win_nxt[j] = cur[PAD-j];
          default:          win_nxt[j] = cur[0];
        endcase
      end
      if (!flush) begin
        win_nxt[PAD+PPC+j] = in_px[j];
      end else begin
        unique case (1'b1)
          (mode_q == 2'd0): win_nxt[PAD+PPC+j] = '0;
          (mode_q == 2'd2): win_nxt[PAD+PPC+j] = cur[PPC-2-j];
          default:          win_nxt[PAD+PPC+j] = cur[PPC-1];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= '0;
      prev       <= '0;
      win_q      <= '0;
      mode_q     <= '0;
      first_pend <= 1'b0;
      o_valid    <= 1'b0;
      o_first    <= 1'b0;
      o_last     <= 1'b0;
      o_odd_line <= 1'b0;
      o_de_dly   <= '0;
    end else begin
      if (!i_vs) begin
        mode_q <= i_pad_mode;
      end
      if (clr) begin
        cur        <= '0;
        prev       <= '0;
        first_pend <= 1'b0;
        o_valid    <= 1'b0;
        o_first    <= 1'b0;
        o_last     <= 1'b0;
        o_de_dly   <= '0;
        if (!i_vs) begin
          o_odd_line <= 1'b0;
        end
      end else begin
        o_de_dly[0] <= i_de;
        for (int k = 1; k < DE_DLY; k++) begin
          o_de_dly[k] <= o_de_dly[k-1];
        end
        o_valid <= emit;
        if (emit) begin
          win_q   <= win_nxt;
          o_first <= first_pend;
          o_last  <= flush;
        end
        if (flush) begin
          o_odd_line <= !o_odd_line;
        end
        if (emit && !flush) begin
          prev <= cur[PPC-1:PPC-PAD];
        end
        if (load) begin
          cur        <= in_px;
          first_pend <= (state == IDLE);
        end
      end
    end
  end

endmodule
